// File: rtl/deal_controller_if.sv
// Handshake and data bundle between the deal controller, its deck and the game logic.
// Each signal name carries its direction as seen from the controller.
interface deal_controller_if #(
   parameter int NUM_PLAYERS = 4
);
   logic                       i_start;
   logic [NUM_PLAYERS-1:0]     i_draw_req;
   logic [3*NUM_PLAYERS-1:0]   i_draw_cnt;
   logic                       i_play_valid;
   logic [5:0]                 i_play_card;
   logic                       o_deck_start;
   logic                       o_deck_insert;
   logic [2:0]                 o_deck_draw;
   logic [5:0]                 o_deck_prev_card;
   logic                       i_deck_done;
   logic                       i_deck_drawn;
   logic [5:0]                 i_deck_card;
   logic                       o_card_valid;
   logic [5:0]                 o_card;
   logic [1:0]                 o_card_player;
   logic [NUM_PLAYERS-1:0]     o_grant;
   logic [5:0]                 o_top_card;
   logic                       o_ready;
   logic                       o_error;

   modport master (
      output i_start, i_draw_req, i_draw_cnt, i_play_valid, i_play_card,
      output i_deck_done, i_deck_drawn, i_deck_card,
      input  o_deck_start, o_deck_insert, o_deck_draw, o_deck_prev_card,
      input  o_card_valid, o_card, o_card_player, o_grant, o_top_card, o_ready, o_error
   );

   modport slave (
      input  i_start, i_draw_req, i_draw_cnt, i_play_valid, i_play_card,
      input  i_deck_done, i_deck_drawn, i_deck_card,
      output o_deck_start, o_deck_insert, o_deck_draw, o_deck_prev_card,
      output o_card_valid, o_card, o_card_player, o_grant, o_top_card, o_ready, o_error
   );
endinterface

// File: rtl/deal_controller.sv
// Card game deal controller: shuffle, deal, flip the first discard, then serve plays and draws.
// Optional DEAL_TIMEOUT_EN adds a per-wait watchdog that latches an ERROR state.
module deal_controller #(
   parameter int NUM_PLAYERS = 4,
   parameter int HAND_SIZE   = 7
) (
   input logic               i_clk,
   input logic               i_rst_n,
   deal_controller_if.slave  bus
);

   localparam int TOTAL = NUM_PLAYERS * HAND_SIZE;

   typedef enum logic [3:0] {
      IDLE, SHUFFLE, SHUF_WAIT, DEAL_REQ, DEAL_WAIT, FLIP_REQ, FLIP_WAIT,
      READY, DRAW_REQ, DRAW_WAIT, INSERT, INS_WAIT
`ifdef DEAL_TIMEOUT_EN
      , ERROR
`endif
   } state_t;

   state_t      state_reg;
   logic [5:0]  deal_cnt_reg;
   logic [1:0]  deal_player_reg;
   logic [1:0]  draw_player_reg;
   logic [1:0]  ptr_reg;
   logic [2:0]  draws_left_reg;
   logic        shuf_armed_reg;
   logic        reflip_reg;

   logic                   deck_start_reg;
   logic                   deck_insert_reg;
   logic [2:0]             deck_draw_reg;
   logic [5:0]             prev_card_reg;
   logic                   card_valid_reg;
   logic [5:0]             card_reg;
   logic [1:0]             card_player_reg;
   logic [NUM_PLAYERS-1:0] grant_reg;
   logic [5:0]             top_card_reg;
   logic                   ready_reg;

   // Round-robin candidates: rr_idx[k] is the player k seats after the pointer.
   logic [1:0] rr_idx [NUM_PLAYERS];
   generate
      for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_rr
         logic [2:0] seat_sum;
         assign seat_sum   = {1'b0, ptr_reg} + 3'(gi);
         assign rr_idx[gi] = (seat_sum >= 3'(NUM_PLAYERS)) ? 2'(seat_sum - 3'(NUM_PLAYERS))
                                                           : seat_sum[1:0];
      end
   endgenerate

   logic       pick_valid;
   logic [1:0] pick_idx;
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      for (int off = NUM_PLAYERS - 1; off >= 0; off--) begin
         if (bus.i_draw_req[rr_idx[off]]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_idx[off];
         end
      end
   end

   logic [2:0] pick_code;
   logic [2:0] pick_draws;
   logic [1:0] pick_next;
   logic [1:0] deal_player_next;
   logic       deck_card_wild;

   assign pick_code        = bus.i_draw_cnt[3*int'(pick_idx) +: 3];
   assign pick_draws       = (pick_code == 3'b010) ? 3'd2 :
                             (pick_code == 3'b100) ? 3'd4 : 3'd1;
   assign pick_next        = (pick_idx == 2'(NUM_PLAYERS - 1)) ? 2'd0 : pick_idx + 2'd1;
   assign deal_player_next = (deal_player_reg == 2'(NUM_PLAYERS - 1)) ? 2'd0
                                                                      : deal_player_reg + 2'd1;
   assign deck_card_wild   = (bus.i_deck_card[3:0] == 4'd13) || (bus.i_deck_card[3:0] == 4'd14);

`ifdef DEAL_TIMEOUT_EN
   logic [7:0] wd_reg;
   logic       error_reg;
   logic       in_wait;
   logic       wait_event;
   assign in_wait    = (state_reg == SHUF_WAIT) || (state_reg == DEAL_WAIT) ||
                       (state_reg == FLIP_WAIT) || (state_reg == DRAW_WAIT) ||
                       (state_reg == INS_WAIT);
   assign wait_event = ((state_reg == SHUF_WAIT) || (state_reg == INS_WAIT)) ? bus.i_deck_done
                                                                             : bus.i_deck_drawn;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg       <= IDLE;
         deal_cnt_reg    <= '0;
         deal_player_reg <= '0;
         draw_player_reg <= '0;
         ptr_reg         <= '0;
         draws_left_reg  <= '0;
         shuf_armed_reg  <= 1'b0;
         reflip_reg      <= 1'b0;
         deck_start_reg  <= 1'b0;
         deck_insert_reg <= 1'b0;
         deck_draw_reg   <= '0;
         prev_card_reg   <= '0;
         card_valid_reg  <= 1'b0;
         card_reg        <= '0;
         card_player_reg <= '0;
         grant_reg       <= '0;
         top_card_reg    <= '0;
         ready_reg       <= 1'b0;
`ifdef DEAL_TIMEOUT_EN
         wd_reg          <= '0;
         error_reg       <= 1'b0;
`endif
      end else begin
         deck_start_reg  <= 1'b0;
         deck_insert_reg <= 1'b0;
         deck_draw_reg   <= 3'b000;
         card_valid_reg  <= 1'b0;
         grant_reg       <= '0;

         case (state_reg)
            IDLE: begin
               if (bus.i_start) begin
                  deck_start_reg <= 1'b1;
                  state_reg      <= SHUFFLE;
               end
            end
            SHUFFLE: begin
               shuf_armed_reg <= 1'b0;
               state_reg      <= SHUF_WAIT;
            end
            SHUF_WAIT: begin
               // A stale done flag right after the start pulse must not count.
               shuf_armed_reg <= 1'b1;
               if (bus.i_deck_done && shuf_armed_reg) begin
                  deal_cnt_reg    <= '0;
                  deal_player_reg <= '0;
                  state_reg       <= DEAL_REQ;
               end
            end
            DEAL_REQ: begin
               if (bus.i_deck_done) begin
                  deck_draw_reg <= 3'b001;
                  state_reg     <= DEAL_WAIT;
               end
            end
            DEAL_WAIT: begin
               if (bus.i_deck_drawn) begin
                  card_valid_reg  <= 1'b1;
                  card_reg        <= bus.i_deck_card;
                  card_player_reg <= deal_player_reg;
                  deal_player_reg <= deal_player_next;
                  if (deal_cnt_reg == 6'(TOTAL - 1)) begin
                     state_reg <= FLIP_REQ;
                  end else begin
                     deal_cnt_reg <= deal_cnt_reg + 6'd1;
                     state_reg    <= DEAL_REQ;
                  end
               end
            end
            FLIP_REQ: begin
               if (bus.i_deck_done) begin
                  deck_draw_reg <= 3'b001;
                  state_reg     <= FLIP_WAIT;
               end
            end
            FLIP_WAIT: begin
               if (bus.i_deck_drawn) begin
                  top_card_reg <= bus.i_deck_card;
                  if (deck_card_wild) begin
                     prev_card_reg   <= bus.i_deck_card;
                     deck_insert_reg <= 1'b1;
                     reflip_reg      <= 1'b1;
                     state_reg       <= INSERT;
                  end else begin
                     ready_reg <= 1'b1;
                     state_reg <= READY;
                  end
               end
            end
            READY: begin
               if (bus.i_start) begin
                  ready_reg      <= 1'b0;
                  deck_start_reg <= 1'b1;
                  state_reg      <= SHUFFLE;
               end else if (bus.i_play_valid) begin
                  ready_reg       <= 1'b0;
                  top_card_reg    <= bus.i_play_card;
                  prev_card_reg   <= top_card_reg;
                  deck_insert_reg <= 1'b1;
                  reflip_reg      <= 1'b0;
                  state_reg       <= INSERT;
               end else if (pick_valid) begin
                  ready_reg       <= 1'b0;
                  grant_reg       <= NUM_PLAYERS'(1) << pick_idx;
                  draw_player_reg <= pick_idx;
                  draws_left_reg  <= pick_draws;
                  ptr_reg         <= pick_next;
                  state_reg       <= DRAW_REQ;
               end
            end
            DRAW_REQ: begin
               if (bus.i_deck_done) begin
                  deck_draw_reg <= 3'b001;
                  state_reg     <= DRAW_WAIT;
               end
            end
            DRAW_WAIT: begin
               if (bus.i_deck_drawn) begin
                  card_valid_reg  <= 1'b1;
                  card_reg        <= bus.i_deck_card;
                  card_player_reg <= draw_player_reg;
                  if (draws_left_reg == 3'd1) begin
                     ready_reg <= 1'b1;
                     state_reg <= READY;
                  end else begin
                     draws_left_reg <= draws_left_reg - 3'd1;
                     state_reg      <= DRAW_REQ;
                  end
               end
            end
            INSERT: begin
               state_reg <= INS_WAIT;
            end
            INS_WAIT: begin
               if (bus.i_deck_done) begin
                  if (reflip_reg) begin
                     reflip_reg <= 1'b0;
                     state_reg  <= FLIP_REQ;
                  end else begin
                     ready_reg <= 1'b1;
                     state_reg <= READY;
                  end
               end
            end
`ifdef DEAL_TIMEOUT_EN
            ERROR: begin
               state_reg <= ERROR;
            end
`endif
            default: state_reg <= IDLE;
         endcase

`ifdef DEAL_TIMEOUT_EN
         // Overrides the case transition: 255 silent cycles in any wait is fatal.
         if (in_wait && !wait_event) begin
            if (wd_reg == 8'd254) begin
               state_reg <= ERROR;
               error_reg <= 1'b1;
            end else begin
               wd_reg <= wd_reg + 8'd1;
            end
         end else begin
            wd_reg <= '0;
         end
`endif
      end
   end

   assign bus.o_deck_start     = deck_start_reg;
   assign bus.o_deck_insert    = deck_insert_reg;
   assign bus.o_deck_draw      = deck_draw_reg;
   assign bus.o_deck_prev_card = prev_card_reg;
   assign bus.o_card_valid     = card_valid_reg;
   assign bus.o_card           = card_reg;
   assign bus.o_card_player    = card_player_reg;
   assign bus.o_grant          = grant_reg;
   assign bus.o_top_card       = top_card_reg;
   assign bus.o_ready          = ready_reg;
`ifdef DEAL_TIMEOUT_EN
   assign bus.o_error          = error_reg;
`else
   assign bus.o_error          = 1'b0;
`endif

endmodule

// File: tb/tb_deal_controller.sv
// Bench for deal_controller: deck responder, output monitor, and a game-rule reference model.
// Timeout checks run only when DEAL_TIMEOUT_EN is defined.
module tb_deal_controller;
   localparam int NP = 4;
   localparam int HS = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   deal_controller_if #(.NUM_PLAYERS(NP)) bus ();

   deal_controller #(.NUM_PLAYERS(NP), .HAND_SIZE(HS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   logic [7:0] card_q[$];
   logic [5:0] ins_q[$];
   int         grant_q[$];
   logic [5:0] deck_q[$];
   int         start_cnt   = 0;
   int         overlap_cnt = 0;
   int         cmd_cnt     = 0;
   logic       err_seen    = 1'b0;
   logic       deck_stall  = 1'b0;
   int         model_ptr   = 0;
   logic [5:0] model_top   = 6'h00;

   // Observed DUT activity, sampled on the falling edge.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus.o_card_valid) card_q.push_back({bus.o_card_player, bus.o_card});
         if (bus.o_deck_insert) ins_q.push_back(bus.o_deck_prev_card);
         for (int p = 0; p < NP; p++) if (bus.o_grant[p]) grant_q.push_back(p);
         if (bus.o_deck_start) start_cnt++;
         if ((int'(bus.o_deck_start) + int'(bus.o_deck_insert) + int'(bus.o_deck_draw != 3'b000)) > 1)
            overlap_cnt++;
         if (bus.o_deck_start || bus.o_deck_insert || (bus.o_deck_draw != 3'b000)) cmd_cnt++;
         if (bus.o_error) err_seen = 1'b1;
      end
   end

   // Deck: done drops on any command; a draw returns its card 3 cycles later.
   initial begin : deck_model
      int   busy;
      logic busy_draw;
      busy = 0;
      busy_draw = 1'b0;
      bus.i_deck_done  = 1'b1;
      bus.i_deck_drawn = 1'b0;
      bus.i_deck_card  = 6'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            bus.i_deck_done  = 1'b1;
            bus.i_deck_drawn = 1'b0;
         end else begin
            if (bus.i_deck_drawn) begin
               bus.i_deck_drawn = 1'b0;
               bus.i_deck_done  = 1'b1;
            end
            if (busy > 0) begin
               busy--;
               if (busy == 0) begin
                  if (busy_draw) begin
                     bus.i_deck_drawn = 1'b1;
                     if (deck_q.size() > 0) bus.i_deck_card = deck_q.pop_front();
                     else bus.i_deck_card = 6'h01;
                  end else begin
                     bus.i_deck_done = 1'b1;
                  end
               end
            end
            if (bus.o_deck_start) begin
               bus.i_deck_done = 1'b0; busy = 4; busy_draw = 1'b0;
            end else if (bus.o_deck_insert) begin
               bus.i_deck_done = 1'b0; busy = 2; busy_draw = 1'b0;
            end else if (bus.o_deck_draw == 3'b001) begin
               bus.i_deck_done = 1'b0;
               if (!deck_stall) begin busy = 3; busy_draw = 1'b1; end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      if (|(bus.i_draw_req & bus.o_grant)) bus.i_draw_req = bus.i_draw_req & ~bus.o_grant;
   endtask

   task automatic wait_ready(input int max, input string tag);
      int n;
      n = 0;
      while (!(bus.o_ready && (bus.i_draw_req == '0)) && n < max) begin
         step();
         n++;
      end
      check({tag, "_ready_timeout"}, 32'(n < max), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"},      32'(bus.o_ready), 32'd0);
      check({tag, "_top"},        32'(bus.o_top_card), 32'd0);
      check({tag, "_card_valid"}, 32'(bus.o_card_valid), 32'd0);
      check({tag, "_card"},       32'({bus.o_card_player, bus.o_card}), 32'd0);
      check({tag, "_grant"},      32'(bus.o_grant), 32'd0);
      check({tag, "_deck_cmds"},  32'({bus.o_deck_start, bus.o_deck_insert, bus.o_deck_draw}), 32'd0);
      check({tag, "_prev_card"},  32'(bus.o_deck_prev_card), 32'd0);
      check({tag, "_error"},      32'(bus.o_error), 32'd0);
   endtask

   function automatic int draws_for(input logic [2:0] code);
      case (code)
         3'b010:  return 2;
         3'b100:  return 4;
         default: return 1;
      endcase
   endfunction

   task automatic run_game(input int n_wild, input logic fixed_flip, input string tag);
      logic [5:0] deal_c[$];
      logic [5:0] exp_ins[$];
      logic [5:0] c;
      logic [3:0] v;
      int         starts_before;
      card_q.delete(); ins_q.delete(); deal_c.delete(); exp_ins.delete();
      for (int i = 0; i < NP * HS; i++) begin
         c = 6'($urandom_range(0, 63));
         deal_c.push_back(c);
         deck_q.push_back(c);
      end
      if (fixed_flip) begin
         deck_q.push_back(6'h0D); exp_ins.push_back(6'h0D);
         deck_q.push_back(6'h05); model_top = 6'h05;
      end else begin
         for (int i = 0; i < n_wild; i++) begin
            c = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 4'd13 : 4'd14};
            deck_q.push_back(c); exp_ins.push_back(c);
         end
         v = 4'($urandom_range(0, 13));
         if (v == 4'd13) v = 4'd15;
         c = {2'($urandom_range(0, 3)), v};
         deck_q.push_back(c); model_top = c;
      end
      starts_before = start_cnt;
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      repeat (10) step();
      // Both must be ignored mid-deal.
      bus.i_start = 1'b1; bus.i_play_valid = 1'b1; bus.i_play_card = 6'h3F;
      step();
      bus.i_start = 1'b0; bus.i_play_valid = 1'b0;
      wait_ready(3000, tag);
      check({tag, "_start_pulses"}, 32'(start_cnt - starts_before), 32'd1);
      check({tag, "_deal_count"}, 32'(card_q.size()), 32'(NP * HS));
      for (int i = 0; i < NP * HS; i++)
         if (i < card_q.size())
            check($sformatf("%s_deal%0d", tag, i), 32'(card_q[i]), 32'({2'(i % NP), deal_c[i]}));
      check({tag, "_insert_count"}, 32'(ins_q.size()), 32'(exp_ins.size()));
      for (int i = 0; i < exp_ins.size(); i++)
         if (i < ins_q.size())
            check($sformatf("%s_insert%0d", tag, i), 32'(ins_q[i]), 32'(exp_ins[i]));
      check({tag, "_top"}, 32'(bus.o_top_card), 32'(model_top));
   endtask

   task automatic run_round(input logic do_play, input logic [5:0] pcard,
                            input logic [NP-1:0] mask, input logic [3*NP-1:0] codes,
                            input string tag);
      logic [7:0]    exp_cards[$];
      int            exp_gr[$];
      logic [5:0]    exp_ins[$];
      logic [NP-1:0] pending;
      logic [5:0]    c;
      int            p;
      card_q.delete(); ins_q.delete(); grant_q.delete();
      if (do_play) begin
         exp_ins.push_back(model_top);
         model_top = pcard;
      end
      pending = mask;
      while (pending != '0) begin
         p = -1;
         for (int off = 0; off < NP && p < 0; off++)
            if (pending[(model_ptr + off) % NP]) p = (model_ptr + off) % NP;
         exp_gr.push_back(p);
         pending[p] = 1'b0;
         model_ptr = (p + 1) % NP;
         for (int k = 0; k < draws_for(codes[3*p +: 3]); k++) begin
            c = 6'($urandom_range(0, 63));
            deck_q.push_back(c);
            exp_cards.push_back({2'(p), c});
         end
      end
      bus.i_draw_cnt   = codes;
      bus.i_draw_req   = mask;
      bus.i_play_valid = do_play;
      bus.i_play_card  = pcard;
      step();
      bus.i_play_valid = 1'b0;
      wait_ready(2000, tag);
      check({tag, "_grant_count"}, 32'(grant_q.size()), 32'(exp_gr.size()));
      for (int i = 0; i < exp_gr.size(); i++)
         if (i < grant_q.size())
            check($sformatf("%s_grant%0d", tag, i), 32'(grant_q[i]), 32'(exp_gr[i]));
      check({tag, "_card_count"}, 32'(card_q.size()), 32'(exp_cards.size()));
      for (int i = 0; i < exp_cards.size(); i++)
         if (i < card_q.size())
            check($sformatf("%s_card%0d", tag, i), 32'(card_q[i]), 32'(exp_cards[i]));
      check({tag, "_insert_count"}, 32'(ins_q.size()), 32'(exp_ins.size()));
      if (exp_ins.size() > 0 && ins_q.size() > 0)
         check({tag, "_insert_prev"}, 32'(ins_q[0]), 32'(exp_ins[0]));
      check({tag, "_top"}, 32'(bus.o_top_card), 32'(model_top));
      $display("round %s: play=%0d mask=%b grants=%0d cards=%0d", tag, do_play, mask,
               grant_q.size(), card_q.size());
   endtask

   initial begin : main
      logic [NP-1:0]   m;
      logic [3*NP-1:0] cd;
      logic            pl;
      logic [5:0]      pc;
      int              n;
      int              snap;
      bus.i_start = 1'b0; bus.i_draw_req = '0; bus.i_draw_cnt = '0;
      bus.i_play_valid = 1'b0; bus.i_play_card = 6'h00;
      rst_n = 1'b0;
      repeat (3) step();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (3) step();
      check("idle_no_cmds", 32'(cmd_cnt), 32'd0);

      run_game(0, 1'b1, "game1");
      run_round(1'b0, 6'h00, 4'b1010, {3'b010, 3'b000, 3'b010, 3'b000}, "rr_1010");
      run_round(1'b1, 6'h17, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b001}, "play_vs_draw");
      for (int r = 0; r < 8; r++) begin
         m  = NP'($urandom_range(0, 15));
         cd = 12'($urandom);
         pl = 1'($urandom_range(0, 1));
         pc = 6'($urandom);
         if (m == '0) pl = 1'b1;
         run_round(pl, pc, m, cd, $sformatf("rnd%0d", r));
      end

      // Reset while a deal draw is outstanding.
      card_q.delete();
      for (int i = 0; i < NP * HS; i++) deck_q.push_back(6'($urandom_range(0, 63)));
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      n = 0;
      while (!((bus.o_deck_draw == 3'b001) && (card_q.size() >= 3)) && n < 500) begin
         step();
         n++;
      end
      check("rst_reach_deal_wait", 32'(n < 500), 32'd1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      repeat (3) step();
      rst_n = 1'b1;
      deck_q.delete();
      model_ptr = 0;
      model_top = 6'h00;
      snap = cmd_cnt;
      repeat (20) step();
      check("rst_no_cmds", 32'(cmd_cnt - snap), 32'd0);

      run_game(2, 1'b0, "game2");
      run_round(1'b0, 6'h00, 4'b1111, {3'b001, 3'b001, 3'b001, 3'b001}, "ptr_after_rst");

`ifdef DEAL_TIMEOUT_EN
      deck_stall = 1'b1;
      deck_q.delete();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      n = 0;
      while ((bus.o_deck_draw != 3'b001) && n < 200) begin step(); n++; end
      check("wd_reach_deal_wait", 32'(n < 200), 32'd1);
      n = 0;
      while (!bus.o_error && n < 400) begin step(); n++; end
      check("wd_latency", 32'(n), 32'd255);
      check("wd_ready_low", 32'(bus.o_ready), 32'd0);
      snap = start_cnt;
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      repeat (5) step();
      check("err_sticky", 32'(bus.o_error), 32'd1);
      check("err_start_ignored", 32'(start_cnt - snap), 32'd0);
      rst_n = 1'b0;
      #1;
      check("err_cleared_by_rst", 32'(bus.o_error), 32'd0);
      step();
      rst_n = 1'b1;
      deck_stall = 1'b0;
`else
      check("no_error", 32'(err_seen), 32'd0);
`endif

      check("deck_cmd_exclusive", 32'(overlap_cnt), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/deal_controller.md
DEAL_CONTROLLER -- requirements
Module: deal_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 4, number of players (2..4).
REQ-002 Parameter HAND_SIZE, default 7, cards dealt per player at game start (1..15).
REQ-003 i_clk  input  1  single clock, rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_start  input  1  pulse; begins shuffle-and-deal sequence.
REQ-006 i_draw_req  input  NUM_PLAYERS  per-player draw request, level, held until o_grant.
REQ-007 i_draw_cnt  input  3*NUM_PLAYERS  per-player count code, 3 bits each: 001 one, 010 two, 100 four.
REQ-008 i_play_valid / i_play_card  input  1 / 6  pulse plus new top card {color[1:0], value[3:0]}.
REQ-009 o_deck_start, o_deck_insert  output  1 each  one-cycle command pulses to deck.
REQ-010 o_deck_draw  output  3  deck draw command; only 000 or 001 driven.
REQ-011 o_deck_prev_card  output  6  card returned to deck on insert.
REQ-012 i_deck_done, i_deck_drawn  input  1 each  deck idle flag; deck card-taken pulse.
REQ-013 i_deck_card  input  6  deck top card, valid when i_deck_drawn=1.
REQ-014 o_card_valid / o_card / o_card_player  output  1 / 6 / 2  one-cycle delivery of a dealt or drawn card and its owner.
REQ-015 o_grant  output  NUM_PLAYERS  one-hot, one-cycle pulse when a draw request is accepted.
REQ-016 o_top_card  output  6  current discard top card.
REQ-017 o_ready, o_error  output  1 each  accepting play/draw; watchdog fault.

Function
REQ-018 States: IDLE, SHUFFLE, SHUF_WAIT, DEAL_REQ, DEAL_WAIT, FLIP_REQ, FLIP_WAIT, READY, DRAW_REQ, DRAW_WAIT, INSERT, INS_WAIT, ERROR.
REQ-019 IDLE or READY + i_start: to SHUFFLE; o_deck_start=1 that cycle; to SHUF_WAIT; leave when i_deck_done=1 at least 2 cycles after pulse.
REQ-020 Every deck draw: in *_REQ, wait for i_deck_done=1, then drive o_deck_draw=001 for exactly one cycle; in *_WAIT, capture i_deck_card on the cycle i_deck_drawn=1.
REQ-021 Deal: NUM_PLAYERS*HAND_SIZE single draws; card k to player k mod NUM_PLAYERS; o_card_valid pulses the cycle after capture.
REQ-022 Flip: one draw into o_top_card, no o_card_valid; value 13 or 14 (wild): INSERT that card, flip again.
REQ-023 READY: o_ready=1; i_play_valid has priority over draw requests in the same cycle.
REQ-024 Play: o_top_card<=i_play_card next cycle; INSERT pulses o_deck_insert with o_deck_prev_card=old top; INS_WAIT until i_deck_done=1; back to READY.
REQ-025 Draw arbitration: round-robin from pointer (reset 0); grant first requester at or after pointer; pointer<=granted+1 mod NUM_PLAYERS.
REQ-026 Granted count 001/010/100 yields 1/2/4 sequential single draws to that player; invalid code treated as 001.
REQ-027 i_play_valid, i_draw_req ignored while o_ready=0; i_start ignored outside IDLE and READY.
REQ-028 o_deck_draw, o_deck_start, o_deck_insert never asserted in the same cycle.

Reset
REQ-029 Reset: state IDLE, pointer 0, all outputs 0, o_top_card 0, counters 0.
REQ-030 Reset mid-sequence abandons it; no further deck commands until next i_start.

Configuration
REQ-031 DEAL_TIMEOUT_EN defined: 8-bit watchdog per *_WAIT state; 255 cycles without i_deck_drawn/i_deck_done moves to ERROR, o_error=1 until reset; i_start ignored in ERROR.
REQ-032 DEAL_TIMEOUT_EN undefined: waits are unbounded, o_error tied 0, ERROR state absent.

Verification
REQ-033 Deck model (done, drawn 3 cycles after draw), NUM_PLAYERS=4, HAND_SIZE=7, i_start -> 28 o_card_valid, owners 0,1,2,3 repeating, then o_ready=1.
REQ-034 Flip returns 0x0D then 0x05 -> one o_deck_insert with prev_card 0x0D; o_top_card=0x05.
REQ-035 READY, i_draw_req=4'b1010 both cnt 010, pointer 0 -> o_grant=0010, two cards to player 1, then o_grant=1000, two cards to player 3.
REQ-036 Same cycle i_play_valid card 0x17 and i_draw_req=0001 -> play served first, insert old top, then grant player 0.
REQ-037 Reset asserted in DEAL_WAIT -> all outputs 0 next edge, no deck commands until i_start.
REQ-038 DEAL_TIMEOUT_EN, deck never drawn -> o_error=1 after 255 cycles in DEAL_WAIT.
